// File: rtl/div_32bit_seq_if.sv
// Request/response bundle between the core's execute stage and the sequential divider.
// The core drives the request side; the divider drives busy/done/result.
interface div_32bit_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, dividend, divisor,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor,
        output busy, done, result
    );
endinterface

// File: rtl/div_32bit_seq.sv
// Radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Fixed 34-cycle latency, or 1 cycle for divide-by-zero and signed overflow.
module div_32bit_seq (
    input  logic              clk,
    input  logic              rst_n,
    div_32bit_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic        sel_rem_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] dvs_reg;
    logic [4:0]  count_reg;
    logic [31:0] result_reg;
    logic        busy_reg;
    logic        done_reg;

    // Operand decode, valid only while sampling a start in IDLE.
    logic        is_signed;
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_inv;
    logic [31:0] dvs_inv;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic        div_by_zero;
    logic        sgn_overflow;
    logic [31:0] special_result;

    assign is_signed = ~bus.op[0];
    assign dvd_neg   = is_signed & bus.dividend[31];
    assign dvs_neg   = is_signed & bus.divisor[31];

    // Conditional two's complement: invert per bit, then add the negate flag.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_inv
            assign dvd_inv[gi] = bus.dividend[gi] ^ dvd_neg;
            assign dvs_inv[gi] = bus.divisor[gi]  ^ dvs_neg;
        end
    endgenerate

    assign dvd_mag = dvd_inv + {31'd0, dvd_neg};
    assign dvs_mag = dvs_inv + {31'd0, dvs_neg};

    assign div_by_zero  = (bus.divisor == 32'd0);
    assign sgn_overflow = is_signed & (bus.dividend == 32'h8000_0000)
                                    & (bus.divisor  == 32'hFFFF_FFFF);

    always_comb begin
        special_result = 32'd0;
        if (div_by_zero)
            special_result = bus.op[1] ? bus.dividend : 32'hFFFF_FFFF;
        else
            special_result = bus.op[1] ? 32'd0 : 32'h8000_0000;
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so after the shift it fits in 33 bits and trial[32] is the borrow.
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic        trial_ok;

    assign rem_shift = {rem_reg, quo_reg[31]};
    assign trial     = rem_shift - {1'b0, dvs_reg};
    assign trial_ok  = ~trial[32];

    logic [31:0] quo_final;
    logic [31:0] rem_final;

    assign quo_final = neg_q_reg ? (32'd0 - quo_reg) : quo_reg;
    assign rem_final = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sel_rem_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            rem_reg     <= 32'd0;
            quo_reg     <= 32'd0;
            dvs_reg     <= 32'd0;
            count_reg   <= 5'd0;
            result_reg  <= 32'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sel_rem_reg <= bus.op[1];
                        neg_q_reg   <= dvd_neg ^ dvs_neg;
                        neg_r_reg   <= dvd_neg;
                        rem_reg     <= 32'd0;
                        quo_reg     <= dvd_mag;
                        dvs_reg     <= dvs_mag;
                        count_reg   <= 5'd0;
                        busy_reg    <= 1'b1;
                        if (div_by_zero || sgn_overflow) begin
                            result_reg <= special_result;
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            done_reg   <= 1'b0;
                            state_reg  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg   <= trial_ok ? trial[31:0] : rem_shift[31:0];
                    quo_reg   <= {quo_reg[30:0], trial_ok};
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31)
                        state_reg <= FIX;
                end
                FIX: begin
                    result_reg <= sel_rem_reg ? rem_final : quo_final;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Scoreboard bench for div_32bit_seq: directed RISC-V corner cases plus random operands,
// checking result, latency, busy framing, start-while-busy and mid-operation reset.
module tb_div_32bit_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   last_t0 = 0;
    bit   post_done = 1'b0;
    logic [31:0] last_res = 32'd0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];

    div_32bit_seq_if dif ();

    div_32bit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent reference using the simulator's signed/unsigned arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (o)
            2'b00: if (b == 0) return 32'hFFFF_FFFF;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                   else return 32'(sa / sb);
            2'b01: if (b == 0) return 32'hFFFF_FFFF;
                   else return a / b;
            2'b10: if (b == 0) return a;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                   else return 32'(sa % sb);
            default: if (b == 0) return a;
                     else return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit track);
        exp_t e;
        @(posedge clk); #1;
        dif.start    = 1'b1;
        dif.op       = o;
        dif.dividend = a;
        dif.divisor  = b;
        last_t0      = cyc;
        if (track) begin
            e.res = exp_res; e.lat = exp_lat; e.t0 = cyc; e.o = o; e.a = a; e.b = b;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        dif.start    = 1'b0;
        dif.op       = 2'($urandom);
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_val("timeout_pending", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
        issue(o, a, b, exp_res, exp_lat, 1'b1);
        wait_done(60);
    endtask

    // Output side of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (post_done) begin
            check_val("busy_after_done", {31'd0, dif.busy}, 32'd0);
            check_val("result_hold", dif.result, last_res);
            post_done = 1'b0;
        end
        if (dif.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", {31'd0, dif.done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("result", dif.result, e.res);
                check_val("latency", 32'(cyc - e.t0), 32'(e.lat));
                check_val("busy_in_done", {31'd0, dif.busy}, 32'd1);
                $display("txn op=%0d a=%h b=%h result=%h exp=%h lat=%0d",
                         e.o, e.a, e.b, dif.result, e.res, cyc - e.t0);
                last_res  = dif.result;
                post_done = 1'b1;
            end
        end
    end

    initial begin
        int dc0;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        dif.start = 1'b0; dif.op = 2'b00; dif.dividend = 32'd0; dif.divisor = 32'd0;
        repeat (3) @(negedge clk);
        check_val("reset_busy", {31'd0, dif.busy}, 32'd0);
        check_val("reset_done", {31'd0, dif.done}, 32'd0);
        check_val("reset_result", dif.result, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases with hand-computed expectations.
        run(2'b01, 32'd100,        32'd7,          32'd14,         34);
        run(2'b11, 32'd100,        32'd7,          32'd2,          34);
        run(2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
        run(2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
        run(2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          34);
        run(2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        run(2'b11, 32'h8000_0000,  32'd0,          32'h8000_0000,  1);
        run(2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
        run(2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34);
        run(2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  34);
        run(2'b11, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  34);
        run(2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 7) rb = 32'd0;
            if (i % 4 == 1) rb = -rb;
            run(ro, ra, rb, ref_result(ro, ra, rb), ref_lat(ro, ra, rb));
        end

        // A start pulse while busy must be ignored.
        dc0 = done_cnt;
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b1);
        while (cyc < last_t0 + 10) @(posedge clk);
        #1;
        dif.start = 1'b1; dif.op = 2'b00; dif.dividend = 32'd5; dif.divisor = 32'd0;
        @(posedge clk); #1;
        dif.start = 1'b0;
        wait_done(60);
        repeat (10) @(negedge clk);
        check_val("busy_start_done_count", 32'(done_cnt - dc0), 32'd1);

        // Asynchronous reset in the middle of a division.
        issue(2'b01, 32'd1000, 32'd3, 32'd0, 34, 1'b0);
        while (cyc < last_t0 + 15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", {31'd0, dif.busy}, 32'd0);
        check_val("midrst_done", {31'd0, dif.done}, 32'd0);
        check_val("midrst_result", dif.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc0 = done_cnt;
        repeat (40) @(negedge clk);
        check_val("post_rst_no_done", 32'(done_cnt - dc0), 32'd0);
        check_val("post_rst_idle", {31'd0, dif.busy}, 32'd0);
        run(2'b01, 32'd9, 32'd3, 32'd3, 34);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_32bit_seq.md
# div_32bit_seq

Sequential 32-bit integer divider implementing the RISC-V M-extension DIV, DIVU, REM and REMU operations. It uses a radix-2 restoring shift-subtract loop, so it is the subtraction-driven counterpart of the carry-lookahead adder datapath. It sits beside the ALU as a multi-cycle execute unit. The core issues a single-cycle `start` pulse and stalls on `busy` until `done`.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clk` — in — 1 — single clock, rising-edge.
- `rst_n` — in — 1 — reset, asynchronous, active-low.
- `start` — in — 1 — request a division. Sampled only in IDLE.
- `op` — in — 2 — funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled with `start`.
- `dividend` — in — 32 — rs1. Sampled with `start`.
- `divisor` — in — 32 — rs2. Sampled with `start`.
- `busy` — out — 1 — high whenever state ≠ IDLE.
- `done` — out — 1 — one-cycle pulse; `result` is valid in this cycle.
- `result` — out — 32 — quotient (DIV/DIVU) or remainder (REM/REMU). Held until the next accepted `start`.

## Operation
States: IDLE, CALC, FIX, DONE. `busy` and `done` are decoded from the registered state.

- **IDLE**
  - On `start`=1: latch `op`. Compute neg_q and neg_r.
    - neg_q = signed op & (dividend[31] ^ divisor[31]).
    - neg_r = signed op & dividend[31].
  - Load magnitudes. For signed ops this is the two's-complement absolute value; 0x80000000 maps to unsigned 0x80000000.
  - Set rem=0, quo=|dividend|, count=0.
  - Special cases go directly to DONE with `result` loaded:
    - divisor==0: quotient = 0xFFFFFFFF (both DIV and DIVU); remainder = dividend, unmodified.
    - DIV/REM with dividend==0x80000000 and divisor==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Otherwise go to CALC.
  - With `start`=0: stay in IDLE.
- **CALC** — one step per cycle, 32 steps in total:
  - {rem,quo} <<= 1.
  - trial = rem − |divisor|, computed 33 bits wide.
  - If trial ≥ 0: rem = trial, quo[0] = 1; else quo[0] = 0.
  - count increments by 1. After the step where count==31, go to FIX.
- **FIX**
  - `result` = quotient (negated if neg_q) or remainder (negated if neg_r), selected by op[1].
  - Go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored in CALC, FIX and DONE; there is no queueing.
- Operand inputs may change freely after the `start` cycle.
- Reset (`rst_n`=0, at any time, including mid-operation):
  - state=IDLE; `busy`=0, `done`=0, `result`=0x00000000.
  - rem, quo and count are cleared.
  - In-flight work is discarded and does not resume after reset.

## Timing
Cycle N is the cycle in which `start`=1 is sampled in IDLE.

- Normal case:
  - `busy` is high in cycles N+1 through N+34.
  - CALC occupies N+1..N+32, FIX is N+33, DONE is N+34.
  - `done`=1 in cycle N+34 only.
  - Earliest next `start` is accepted in cycle N+35.
- Special cases (divide by zero, signed overflow):
  - `done`=1 and `busy`=1 in cycle N+1 only.
  - Next `start` can be accepted in N+2.
- `result` changes only on the FIX→DONE or IDLE→DONE edge. It is stable in the `done` cycle and afterwards.
- Latency is data-independent apart from the two special cases.

## Test plan
- DIVU 100 / 7 with `start` in cycle N → `done` only in cycle N+34, `result`=14. Then REMU 100 / 7 → `result`=2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- Divide by zero:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 0x80000000 / 0 → 0x80000000.
  - Both finish with `done` in cycle N+1.
- Signed overflow:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
  - `done` in cycle N+1.
  - DIVU 0x80000000 / 0xFFFFFFFF → 0 via the full 34-cycle path.
- Start while busy:
  - Start DIVU 0xFFFFFFFF / 1.
  - Pulse `start` with different operands in cycle N+10 → ignored; `result`=0xFFFFFFFF at N+34; `done` pulses exactly once.
- Reset mid-operation:
  - Drop `rst_n` asynchronously in cycle N+15 → `busy`, `done` and `result` are 0 immediately.
  - After release, no `done` occurs without a new `start`.
  - A new DIVU 9 / 3 → `result`=3 at its own N+34.
